vga_rx_monitor: RTL and testbench
=================================

# vga_rx_monitor

Sink-side counterpart of the VGA output path. It samples the VGA sync, blank and 24-bit RGB stream the game top drives, and rebuilds pixel coordinates from the sync edges alone. Each frame it checks the timing against 640x480 totals, locks after consecutive good frames, and reports a per-frame RGB checksum. It is used on-chip, looped back from the top's VGA pins, and as a scoreboard in simulation.

## Interface
Parameters:
- H_TOTAL, 800, pixel ticks per line (hsync fall to hsync fall)
- V_TOTAL, 525, lines per frame (vsync fall to vsync fall)
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- LOCK_FRAMES, 2, consecutive good frames required for lock (1..15)

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  reset, asynchronous, active-low
- pix_en  in  1  one-clk pixel strobe; all other inputs sampled only when high
- hsync  in  1  horizontal sync, active-low
- vsync  in  1  vertical sync, active-low
- blank_n  in  1  1 = active pixel
- rgb  in  24  {R,G,B} pixel value
- x  out  10  active-pixel index in current line
- y  out  10  active-line index in current frame
- pix_valid  out  1  one-clk pulse: x, y, pix_rgb describe a sampled active pixel
- pix_rgb  out  24  registered copy of sampled rgb
- locked  out  1  timing locked
- frame_done  out  1  one-clk pulse: frame results below are updated
- frame_ok  out  1  last judged frame met all checks
- frame_sum  out  32  sum of rgb (zero-extended) over active pixels, mod 2^32
- active_count  out  19  active pixels in last judged frame
- err_count  out  8  lock losses, saturating at 255

## Operation
- Edge detect on sampled hsync/vsync: a fall is a 1->0 change between consecutive pix_en samples.
- Line counter (10 bit, saturating at 1023): increments each tick. On an hsync fall, if a previous hsync fall has been seen, line_len_err is set when the count != H_TOTAL. The counter then clears.
- x clears on an hsync fall and increments per active pixel. line_had_active marks the line.
- At an hsync fall with line_had_active set, y increments. A line-counter increment likewise saturates at 1023.
- Active pixels are accumulated into a running sum and a running count.
- On a vsync fall the frame is judged good when all of the following hold:
  - no line_len_err;
  - lines == V_TOTAL;
  - running count == H_ACTIVE*V_ACTIVE;
  - y == V_ACTIVE after the coincident line close.
- The vsync fall then clears the running sum/count, the line count, y and line_len_err.
- When hsync and vsync fall on the same tick, the line closes first (length check, y update) and the frame closes second.
- FSM:
  - HUNT: no judging; on vsync fall -> ACQUIRE with good_cnt=0.
  - ACQUIRE: judge each frame. Good: good_cnt++; at LOCK_FRAMES -> LOCKED. Bad: good_cnt=0, stay in ACQUIRE.
  - LOCKED: good frame stays. Bad frame -> HUNT, err_count++ (saturating).
- locked = (state==LOCKED). frame_done fires for every frame judged in ACQUIRE or LOCKED, never in HUNT.

## Timing
- All outputs are registered. x, y, pix_valid and pix_rgb appear one clk after the pix_en sample that carried them.
- frame_done, frame_ok, frame_sum, active_count and locked update one clk after the pix_en sample holding the vsync fall. frame_done is high for exactly one clk.
- Reset values:
  - all outputs 0;
  - state HUNT;
  - edge history registers 1 (idle sync), so no spurious fall follows reset.
- Reset asserted mid-frame discards all partial counts. The first frame after release is never judged.
- Inputs change only on pix_en cycles; no requirement is placed on inputs when pix_en=0.

## Test plan
- Clean 800x525 stream, pix_en every 2nd clk, hsync low at ticks 656-751, vsync low at lines 490-491, rgb=0x0000FF. Required response:
  - first vsync fall: no frame_done;
  - 2nd and 3rd vsync falls: frame_done, frame_ok=1, active_count=307200, frame_sum=78336000;
  - locked=1 after the 3rd.
- Same stream with rgb=x+y (observed pixel grid). Required: pix_valid with x=0,y=0 on the first active pixel and x=639,y=479 on the last; exactly 307200 pix_valid pulses per frame.
- Locked stream with one 799-tick line. Required: frame_ok=0 at the next frame_done, locked=0, err_count=1, state HUNT; relock after HUNT plus LOCK_FRAMES good frames.
- Hsync and vsync falling on the same tick, normal totals. Required: frame_ok=1 and y counted to 480 before the frame close.
- rst pulsed low mid-line during lock. Required: all outputs 0 immediately; no frame_done at the first vsync fall after release.
- 300 forced lock losses. Required: err_count saturates at 255.

Source files
------------

// File: rtl/vga_rx_monitor.sv
// VGA sink monitor: rebuilds pixel coordinates from sync edges, judges each
// frame against the nominal timing totals, tracks lock and a per-frame RGB sum.
module vga_rx_monitor #(
   parameter int H_TOTAL     = 800,
   parameter int V_TOTAL     = 525,
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int LOCK_FRAMES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_en,
   input  logic        hsync,
   input  logic        vsync,
   input  logic        blank_n,
   input  logic [23:0] rgb,
   output logic [9:0]  x,
   output logic [9:0]  y,
   output logic        pix_valid,
   output logic [23:0] pix_rgb,
   output logic        locked,
   output logic        frame_done,
   output logic        frame_ok,
   output logic [31:0] frame_sum,
   output logic [18:0] active_count,
   output logic [7:0]  err_count
);

   localparam logic [9:0]  H_TOT   = 10'(H_TOTAL);
   localparam logic [9:0]  V_TOT   = 10'(V_TOTAL);
   localparam logic [9:0]  V_ACT   = 10'(V_ACTIVE);
   localparam logic [18:0] ACT_PIX = 19'(H_ACTIVE * V_ACTIVE);
   localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

   typedef enum logic [1:0] {HUNT, ACQUIRE, LOCKED} state_t;

   state_t      state, state_nxt;
   logic [3:0]  good_cnt, good_nxt;
   logic [7:0]  err_nxt;
   logic        judge;

   logic        hs_d, vs_d;
   logic [9:0]  tick_cnt, tick_inc;
   logic        seen_hfall;
   logic [9:0]  x_cnt, x_base;
   logic [9:0]  y_cnt, y_nxt;
   logic [9:0]  line_num, line_nxt;
   logic        had_active;
   logic        len_err, len_err_nxt;
   logic [31:0] sum_acc, sum_nxt;
   logic [18:0] cnt_acc, cnt_nxt;
   logic        hs_fall, vs_fall, act, frame_good;

   always_comb begin
      hs_fall     = pix_en & hs_d & ~hsync;
      vs_fall     = pix_en & vs_d & ~vsync;
      act         = pix_en & blank_n;
      tick_inc    = (tick_cnt == 10'h3FF) ? tick_cnt : tick_cnt + 10'd1;
      len_err_nxt = len_err | (hs_fall & seen_hfall & (tick_inc != H_TOT));
      // The line close is folded in first so a coincident vsync fall sees it.
      y_nxt       = (hs_fall && had_active && y_cnt != 10'h3FF) ? y_cnt + 10'd1 : y_cnt;
      line_nxt    = (hs_fall && line_num != 10'h3FF) ? line_num + 10'd1 : line_num;
      x_base      = hs_fall ? 10'd0 : x_cnt;
      sum_nxt     = sum_acc + (act ? {8'd0, rgb} : 32'd0);
      cnt_nxt     = cnt_acc + {18'd0, act};
      frame_good  = !len_err_nxt && (line_nxt == V_TOT) &&
                    (cnt_nxt == ACT_PIX) && (y_nxt == V_ACT);
   end

   always_comb begin
      state_nxt = state;
      good_nxt  = good_cnt;
      err_nxt   = err_count;
      judge     = 1'b0;
      if (vs_fall) begin
         case (state)
            HUNT: begin
               state_nxt = ACQUIRE;
               good_nxt  = 4'd0;
            end
            ACQUIRE: begin
               judge = 1'b1;
               if (!frame_good) begin
                  good_nxt = 4'd0;
               end else if (good_cnt + 4'd1 >= LOCK_N) begin
                  state_nxt = LOCKED;
                  good_nxt  = 4'd0;
               end else begin
                  good_nxt = good_cnt + 4'd1;
               end
            end
            LOCKED: begin
               judge = 1'b1;
               if (!frame_good) begin
                  state_nxt = HUNT;
                  if (err_count != 8'hFF) err_nxt = err_count + 8'd1;
               end
            end
            default: state_nxt = HUNT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= HUNT;
         good_cnt     <= 4'd0;
         err_count    <= 8'd0;
         locked       <= 1'b0;
         frame_done   <= 1'b0;
         frame_ok     <= 1'b0;
         frame_sum    <= 32'd0;
         active_count <= 19'd0;
         pix_valid    <= 1'b0;
         pix_rgb      <= 24'd0;
         x            <= 10'd0;
         y            <= 10'd0;
         hs_d         <= 1'b1;
         vs_d         <= 1'b1;
         tick_cnt     <= 10'd0;
         seen_hfall   <= 1'b0;
         x_cnt        <= 10'd0;
         y_cnt        <= 10'd0;
         line_num     <= 10'd0;
         had_active   <= 1'b0;
         len_err      <= 1'b0;
         sum_acc      <= 32'd0;
         cnt_acc      <= 19'd0;
      end else begin
         state      <= state_nxt;
         good_cnt   <= good_nxt;
         err_count  <= err_nxt;
         locked     <= (state_nxt == LOCKED);
         frame_done <= judge;
         pix_valid  <= act;
         if (judge) begin
            frame_ok     <= frame_good;
            frame_sum    <= sum_nxt;
            active_count <= cnt_nxt;
         end
         if (pix_en) begin
            hs_d     <= hsync;
            vs_d     <= vsync;
            pix_rgb  <= rgb;
            tick_cnt <= hs_fall ? 10'd0 : tick_inc;
            if (hs_fall) seen_hfall <= 1'b1;
            // A pixel on the closing tick already belongs to the new line.
            had_active <= act | (had_active & ~hs_fall);
            x_cnt      <= act ? x_base + 10'd1 : x_base;
            if (act) begin
               x <= x_base;
               y <= y_nxt;
            end
            if (vs_fall) begin
               sum_acc  <= 32'd0;
               cnt_acc  <= 19'd0;
               line_num <= 10'd0;
               y_cnt    <= 10'd0;
               len_err  <= 1'b0;
            end else begin
               sum_acc  <= sum_nxt;
               cnt_acc  <= cnt_nxt;
               line_num <= line_nxt;
               y_cnt    <= y_nxt;
               len_err  <= len_err_nxt;
            end
         end
      end
   end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Scoreboard bench for vga_rx_monitor on a shrunken raster (6x5 ticks, 3x3 active).
module tb_vga_rx_monitor;
   localparam int HT = 6, VT = 5, HA = 3, VA = 3, LF = 2, HS_T = 4;

   logic clk = 1'b0, rst = 1'b0, pix_en = 1'b0;
   logic hsync = 1'b1, vsync = 1'b1, blank_n = 1'b0;
   logic [23:0] rgb = 24'd0;
   logic [9:0]  x, y;
   logic        pix_valid, locked, frame_done, frame_ok;
   logic [23:0] pix_rgb;
   logic [31:0] frame_sum;
   logic [18:0] active_count;
   logic [7:0]  err_count;

   always #5 clk = ~clk;

   vga_rx_monitor #(.H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
                    .LOCK_FRAMES(LF)) dut (
      .clk(clk), .rst(rst), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
      .blank_n(blank_n), .rgb(rgb), .x(x), .y(y), .pix_valid(pix_valid),
      .pix_rgb(pix_rgb), .locked(locked), .frame_done(frame_done),
      .frame_ok(frame_ok), .frame_sum(frame_sum), .active_count(active_count),
      .err_count(err_count));

   typedef struct {int x; int y; logic [23:0] rgb;} pix_t;
   typedef struct {bit ok; logic [31:0] sum; int cnt; bit lk; int err;} frm_t;
   pix_t pq[$];
   frm_t fq[$];
   int n_cmp = 0, n_bad = 0, fd_cnt = 0, pv_cnt = 0;

   // Reference model: event view of the stream (fall ticks, pixel lists).
   int m_tick, m_last_hf, m_hfalls, m_px, m_y, m_cnt, m_state, m_good, m_err;
   bit m_phs, m_pvs, m_bad, m_lact;
   logic [31:0] m_sum;

   task automatic chk(input string nm, input longint a, input longint e);
      n_cmp++;
      if (a != e) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, a, e);
      end
   endtask

   task automatic mdl_reset();
      m_tick = 0; m_last_hf = -1; m_hfalls = 0; m_px = 0; m_y = 0; m_cnt = 0;
      m_state = 0; m_good = 0; m_err = 0; m_phs = 1; m_pvs = 1; m_bad = 0;
      m_lact = 0; m_sum = 0;
      pq.delete(); fq.delete();
   endtask

   task automatic mdl_tick(input bit hs, input bit vs, input bit bn, input logic [23:0] c);
      bit hf, vf, ok;
      pix_t p;
      frm_t f;
      m_tick++;
      hf = m_phs && !hs; vf = m_pvs && !vs;
      m_phs = hs; m_pvs = vs;
      if (hf) begin
         if (m_last_hf >= 0 && (m_tick - m_last_hf) != HT) m_bad = 1;
         m_last_hf = m_tick; m_hfalls++;
         if (m_lact) m_y++;
         m_lact = 0; m_px = 0;
      end
      if (bn) begin
         p.x = m_px; p.y = m_y; p.rgb = c; pq.push_back(p);
         m_px++; m_lact = 1; m_sum += {8'd0, c}; m_cnt++;
      end
      if (vf) begin
         ok = !m_bad && m_hfalls == VT && m_cnt == HA * VA && m_y == VA;
         if (m_state == 0) begin
            m_state = 1; m_good = 0;
         end else begin
            if (m_state == 1) begin
               if (ok) begin
                  m_good++;
                  if (m_good >= LF) begin m_state = 2; m_good = 0; end
               end else m_good = 0;
            end else if (!ok) begin
               m_state = 0;
               if (m_err < 255) m_err++;
            end
            f.ok = ok; f.sum = m_sum; f.cnt = m_cnt; f.lk = (m_state == 2); f.err = m_err;
            fq.push_back(f);
         end
         m_sum = 0; m_cnt = 0; m_hfalls = 0; m_y = 0; m_bad = 0;
      end
   endtask

   task automatic drive(input bit hs, input bit vs, input bit bn, input logic [23:0] c, input bit gap);
      @(posedge clk); #1;
      pix_en = 1'b1; hsync = hs; vsync = vs; blank_n = bn; rgb = c;
      mdl_tick(hs, vs, bn, c);
      if (gap) begin
         @(posedge clk); #1;
         pix_en = 1'b0; hsync = 1'($urandom); vsync = 1'($urandom);
         blank_n = 1'($urandom); rgb = 24'($urandom);
      end
   endtask

   task automatic idle();
      @(posedge clk); #1;
      pix_en = 1'b0;
   endtask

   // sl: index of a line one tick short (-1 none); co: vsync falls with the
   // last active line's hsync fall; mode 0 blue, 1 x+y, 2 random; lim: tick cap.
   task automatic gen_frame(input int sl, input bit co, input int mode, input bit gap, input int lim);
      int n;
      n = 0;
      for (int l = 0; l < VT; l++) begin
         for (int t = 0; t < ((l == sl) ? HT - 1 : HT); t++) begin
            bit bn, hs, vs;
            logic [23:0] c;
            if (lim >= 0 && n >= lim) return;
            n++;
            bn = (l >= 1) && (l <= VA) && (t < HA);
            hs = (t != HS_T);
            vs = co ? !((l == VA && t >= HS_T) || (l == VA + 1 && t < HS_T)) : (l != 0);
            case (mode)
               0:       c = 24'h0000FF;
               1:       c = 24'(t + l - 1);
               default: c = 24'($urandom);
            endcase
            drive(hs, vs, bn, c, gap);
         end
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " x/y/pv/rgb"}, {x, y, pix_valid, pix_rgb}, 0);
      chk({tag, " lock/done/ok/cnt/err"}, {locked, frame_done, frame_ok, active_count, err_count}, 0);
      chk({tag, " frame_sum"}, frame_sum, 0);
   endtask

   always @(negedge clk) begin : monitor
      pix_t p;
      frm_t f;
      if (rst === 1'b1) begin
         if (pix_valid) begin
            pv_cnt++;
            if (pq.size() == 0) chk("unexpected pix_valid", 1, 0);
            else begin
               p = pq.pop_front();
               chk("pix x", x, p.x);
               chk("pix y", y, p.y);
               chk("pix rgb", pix_rgb, p.rgb);
            end
         end
         if (frame_done) begin
            fd_cnt++;
            if (fq.size() == 0) chk("unexpected frame_done", 1, 0);
            else begin
               f = fq.pop_front();
               chk("frame_ok", frame_ok, f.ok);
               chk("frame_sum", frame_sum, f.sum);
               chk("active_count", active_count, f.cnt);
               chk("locked", locked, f.lk);
               chk("err_count", err_count, f.err);
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: stimulus did not complete");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int fd0, pv0;
      mdl_reset();
      repeat (3) @(posedge clk);
      #1 chk_zero("reset");
      rst = 1'b1;

      // Clean blue stream, pix_en every 2nd clk.
      fd0 = fd_cnt;
      for (int i = 0; i < 4; i++) gen_frame(-1, 0, 0, 1, -1);
      idle();
      chk("frame_done count first 4 vsync falls", fd_cnt - fd0, 3);
      chk("locked after 3rd fall", locked, 1);
      chk("blue frame_ok", frame_ok, 1);
      chk("blue active_count", active_count, HA * VA);
      chk("blue frame_sum", frame_sum, HA * VA * 255);

      // Observed coordinate grid.
      pv0 = pv_cnt;
      for (int i = 0; i < 3; i++) gen_frame(-1, 0, 1, 1, -1);
      idle();
      chk("pix_valid pulses over 3 frames", pv_cnt - pv0, 3 * HA * VA);

      // One short line while locked, then relock.
      gen_frame(2, 0, 2, 0, -1);
      gen_frame(-1, 0, 2, 0, -1);
      idle();
      chk("locked after short line", locked, 0);
      chk("err_count after short line", err_count, 1);
      for (int i = 0; i < 3; i++) gen_frame(-1, 0, 2, 0, -1);
      idle();
      chk("relocked", locked, 1);

      // Coincident hsync/vsync falls.
      for (int i = 0; i < 4; i++) gen_frame(-1, 1, 2, 0, -1);
      idle();
      chk("coincident locked", locked, 1);
      chk("coincident frame_ok", frame_ok, 1);

      // Reset mid-line during lock.
      for (int i = 0; i < 4; i++) gen_frame(-1, 0, 2, 0, -1);
      idle();
      chk("locked before reset", locked, 1);
      gen_frame(-1, 0, 2, 0, HT + 2);
      idle();
      @(posedge clk); #1 rst = 1'b0;
      #2 chk_zero("mid-frame reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      mdl_reset();
      fd0 = fd_cnt;
      gen_frame(-1, 0, 2, 0, -1);
      idle();
      chk("no frame_done at first fall after reset", fd_cnt - fd0, 0);
      gen_frame(-1, 0, 2, 0, -1);
      gen_frame(-1, 0, 2, 0, -1);

      // Forced lock losses.
      for (int i = 0; i < 300; i++) begin
         gen_frame(2, 0, 2, 0, -1);
         for (int k = 0; k < 3; k++) gen_frame(-1, 0, 2, 0, -1);
      end
      idle();
      chk("err_count saturated", err_count, 255);
      chk("locked vs model at end", locked, m_state == 2);
      repeat (3) @(posedge clk);
      chk("pixel queue drained", pq.size(), 0);
      chk("frame queue drained", fq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
